// File: rtl/pa_tcipif_initiator.sv
// pa_tcipif_initiator
// Initiator side of the tightly-coupled IP interface. Takes single-beat
// load/store requests from the LSU, decodes the tcipif address window,
// presents the request to the CLINT until it completes, then returns a
// one-cycle response (read data or error) to the LSU.
//
// Optional feature macro: PA_TCIPIF_TIMEOUT_EN
//   defined   -> 8-bit REQ timeout counter, hung slave returns err
//   undefined -> REQ waits indefinitely for clint_tcipif_cmplt
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a new LSU request (req_rdy = 1)
// REQ   | sel asserted, addr/write/wdata held, waiting for cmplt
// RESP  | resp_vld pulse with rdata/err, returns to IDLE next cycle
//
// Every output is a register or a decode of state only; nothing from the
// LSU inputs or from cmplt reaches an output combinationally.

module pa_tcipif_initiator #(
   parameter logic [15:0] TCIP_BASE_HI = 16'hE000,
   parameter int unsigned TIMEOUT_CYC  = 255
) (
   input  logic        forever_cpuclk,
   input  logic        cpurst_b,
   input  logic        lsu_tcipif_req_vld,
   input  logic [31:0] lsu_tcipif_addr,
   input  logic        lsu_tcipif_write,
   input  logic [31:0] lsu_tcipif_wdata,
   output logic        tcipif_lsu_req_rdy,
   output logic        tcipif_lsu_resp_vld,
   output logic [31:0] tcipif_lsu_rdata,
   output logic        tcipif_lsu_resp_err,
   output logic        tcipif_clint_sel,
   output logic [15:0] tcipif_clint_addr,
   output logic        tcipif_clint_write,
   output logic [31:0] tcipif_clint_wdata,
   input  logic        clint_tcipif_cmplt,
   input  logic [31:0] clint_tcipif_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_q;
   logic        sel_q;
   logic [15:0] addr_q;
   logic        write_q;
   logic [31:0] wdata_q;
   logic        resp_vld_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        req_legal;

`ifdef PA_TCIPIF_TIMEOUT_EN
   localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);
   logic [7:0] to_cnt_q;
`endif

   // Window hit and word alignment decide whether the slave sees the access.
   assign req_legal = (lsu_tcipif_addr[31:16] == TCIP_BASE_HI) &&
                      (lsu_tcipif_addr[1:0] == 2'b00);

   // Transaction FSM with all slave- and LSU-facing outputs registered.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q    <= ST_IDLE;
         sel_q      <= 1'b0;
         addr_q     <= 16'h0000;
         write_q    <= 1'b0;
         wdata_q    <= 32'h0000_0000;
         resp_vld_q <= 1'b0;
         rdata_q    <= 32'h0000_0000;
         err_q      <= 1'b0;
`ifdef PA_TCIPIF_TIMEOUT_EN
         to_cnt_q   <= 8'h00;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               resp_vld_q <= 1'b0;
               if (lsu_tcipif_req_vld) begin
                  if (req_legal) begin
                     state_q <= ST_REQ;
                     sel_q   <= 1'b1;
                     addr_q  <= lsu_tcipif_addr[15:0];
                     write_q <= lsu_tcipif_write;
                     // Loads drive zero write data so the bus never leaks stale stores.
                     wdata_q <= lsu_tcipif_write ? lsu_tcipif_wdata : 32'h0000_0000;
`ifdef PA_TCIPIF_TIMEOUT_EN
                     to_cnt_q <= 8'h00;
`endif
                  end else begin
                     // Out-of-window or misaligned: answer locally, slave never selected.
                     state_q    <= ST_RESP;
                     resp_vld_q <= 1'b1;
                     rdata_q    <= 32'h0000_0000;
                     err_q      <= 1'b1;
                  end
               end
            end

            ST_REQ: begin
               if (clint_tcipif_cmplt) begin
                  // Completion wins even on the terminal-count cycle.
                  state_q    <= ST_RESP;
                  sel_q      <= 1'b0;
                  resp_vld_q <= 1'b1;
                  rdata_q    <= write_q ? 32'h0000_0000 : clint_tcipif_rdata;
                  err_q      <= 1'b0;
               end
`ifdef PA_TCIPIF_TIMEOUT_EN
               else if (to_cnt_q == TO_LIM) begin
                  state_q    <= ST_RESP;
                  sel_q      <= 1'b0;
                  resp_vld_q <= 1'b1;
                  rdata_q    <= 32'h0000_0000;
                  err_q      <= 1'b1;
               end else begin
                  to_cnt_q <= to_cnt_q + 8'h01;
               end
`endif
            end

            ST_RESP: begin
               // LSU cannot stall the response; a late cmplt here is dropped.
               state_q    <= ST_IDLE;
               resp_vld_q <= 1'b0;
            end

            default: begin
               state_q    <= ST_IDLE;
               sel_q      <= 1'b0;
               resp_vld_q <= 1'b0;
            end
         endcase
      end
   end

   assign tcipif_lsu_req_rdy  = (state_q == ST_IDLE);
   assign tcipif_lsu_resp_vld = resp_vld_q;
   assign tcipif_lsu_rdata    = rdata_q;
   assign tcipif_lsu_resp_err = err_q;
   assign tcipif_clint_sel    = sel_q;
   assign tcipif_clint_addr   = addr_q;
   assign tcipif_clint_write  = write_q;
   assign tcipif_clint_wdata  = wdata_q;

endmodule

// File: tb/tb_pa_tcipif_initiator.sv
// Bench for pa_tcipif_initiator: directed LSU transactions with a
// cycle-accurate slave, responses checked through a scoreboard queue.

module tb_pa_tcipif_initiator;

   logic        clk;
   logic        rst_b;
   logic        vld;
   logic [31:0] addr;
   logic        wr;
   logic [31:0] wdata;
   logic        rdy;
   logic        resp_vld;
   logic [31:0] rdata;
   logic        err;
   logic        sel;
   logic [15:0] c_addr;
   logic        c_write;
   logic [31:0] c_wdata;
   logic        cmplt;
   logic [31:0] c_rdata;

   typedef struct {
      logic [31:0] rd;
      logic        er;
   } resp_t;

   resp_t sb_q[$];
   int    n_chk  = 0;
   int    n_pass = 0;

   pa_tcipif_initiator #(
      .TCIP_BASE_HI (16'hE000),
      .TIMEOUT_CYC  (4)
   ) u_dut (
      .forever_cpuclk      (clk),
      .cpurst_b            (rst_b),
      .lsu_tcipif_req_vld  (vld),
      .lsu_tcipif_addr     (addr),
      .lsu_tcipif_write    (wr),
      .lsu_tcipif_wdata    (wdata),
      .tcipif_lsu_req_rdy  (rdy),
      .tcipif_lsu_resp_vld (resp_vld),
      .tcipif_lsu_rdata    (rdata),
      .tcipif_lsu_resp_err (err),
      .tcipif_clint_sel    (sel),
      .tcipif_clint_addr   (c_addr),
      .tcipif_clint_write  (c_write),
      .tcipif_clint_wdata  (c_wdata),
      .clint_tcipif_cmplt  (cmplt),
      .clint_tcipif_rdata  (c_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp)
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      else
         n_pass++;
   endtask

   // Response monitor: every resp_vld pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_b && resp_vld) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
         end else begin
            resp_t e;
            e = sb_q.pop_front();
            chk("resp_rdata", rdata, e.rd);
            chk("resp_err", {31'd0, err}, {31'd0, e.er});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rdy();
      int n = 0;
      while (rdy !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      if (rdy !== 1'b1) chk("rdy_timeout", {31'd0, rdy}, 32'd1);
   endtask

   // One LSU transaction; d = number of cycles sel stays high before cmplt is sampled.
   task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input int d, input logic [31:0] srd, input logic legal);
      resp_t e;
      e.rd = (legal && !w) ? srd : 32'h0;
      e.er = !legal;
      wait_rdy();
      vld = 1'b1; addr = a; wr = w; wdata = wd;
      step();
      vld = 1'b0; addr = $urandom; wdata = $urandom;
      sb_q.push_back(e);
      chk("rdy_after_accept", {31'd0, rdy}, 32'd0);
      if (!legal) begin
         chk("illegal_sel", {31'd0, sel}, 32'd0);
      end else begin
         for (int i = 1; i <= d; i++) begin
            chk("req_sel", {31'd0, sel}, 32'd1);
            chk("req_addr", {16'd0, c_addr}, {16'd0, a[15:0]});
            chk("req_write", {31'd0, c_write}, {31'd0, w});
            chk("req_wdata", c_wdata, w ? wd : 32'h0);
            chk("req_no_resp", {31'd0, resp_vld}, 32'd0);
            if (i == d) begin
               cmplt = 1'b1;
               c_rdata = srd;
            end
            step();
            cmplt = 1'b0;
            c_rdata = $urandom;
         end
         chk("sel_drop", {31'd0, sel}, 32'd0);
      end
      chk("resp_pulse", {31'd0, resp_vld}, 32'd1);
      step();
      chk("rdy_return", {31'd0, rdy}, 32'd1);
      chk("resp_single", {31'd0, resp_vld}, 32'd0);
   endtask

   initial begin
      rst_b = 1'b0; vld = 1'b0; addr = '0; wr = 1'b0; wdata = '0;
      cmplt = 1'b0; c_rdata = '0;
      #12;
      chk("rst_sel", {31'd0, sel}, 32'd0);
      chk("rst_write", {31'd0, c_write}, 32'd0);
      chk("rst_resp_vld", {31'd0, resp_vld}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_addr", {16'd0, c_addr}, 32'd0);
      chk("rst_wdata", c_wdata, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_rdy", {31'd0, rdy}, 32'd1);
      @(negedge clk);
      rst_b = 1'b1;
      step();

      txn(32'hE000_BFF8, 1'b0, 32'hAAAA_5555, 2, 32'h1234_5678, 1'b1);
      txn(32'hE000_0000, 1'b1, 32'hDEAD_BEEF, 1, 32'h5A5A_5A5A, 1'b1);
      txn(32'hE000_0002, 1'b0, 32'h0, 1, 32'h0, 1'b0);
      txn(32'h4000_0000, 1'b0, 32'h0, 1, 32'h0, 1'b0);
      txn(32'hE000_FFFC, 1'b0, 32'h0, 1, 32'hCAFE_F00D, 1'b1);
      txn(32'hE001_0000, 1'b1, 32'h1111_2222, 1, 32'h0, 1'b0);
      // cmplt on the fifth REQ cycle: the terminal-count cycle when timeout is enabled.
      txn(32'hE000_0040, 1'b0, 32'h0, 5, 32'h0BAD_CAFE, 1'b1);

`ifdef PA_TCIPIF_TIMEOUT_EN
      begin
         resp_t e;
         e.rd = 32'h0; e.er = 1'b1;
         wait_rdy();
         vld = 1'b1; addr = 32'hE000_0100; wr = 1'b0; wdata = '0;
         step();
         vld = 1'b0;
         sb_q.push_back(e);
         for (int i = 0; i < 5; i++) begin
            chk("to_sel_high", {31'd0, sel}, 32'd1);
            step();
         end
         chk("to_sel_drop", {31'd0, sel}, 32'd0);
         chk("to_resp", {31'd0, resp_vld}, 32'd1);
         step();
         step();
         step();
         cmplt = 1'b1; c_rdata = 32'hFFFF_FFFF;
         step();
         cmplt = 1'b0;
         for (int i = 0; i < 3; i++) begin
            chk("late_cmplt_ignored", {31'd0, resp_vld}, 32'd0);
            step();
         end
      end
`else
      txn(32'hE000_0200, 1'b0, 32'h0, 12, 32'h7777_0001, 1'b1);
`endif

      // Async reset while the slave is selected: sel drops, no response follows.
      wait_rdy();
      vld = 1'b1; addr = 32'hE000_0300; wr = 1'b0;
      step();
      vld = 1'b0;
      chk("pre_rst_sel", {31'd0, sel}, 32'd1);
      #2;
      rst_b = 1'b0;
      #1;
      chk("async_rst_sel", {31'd0, sel}, 32'd0);
      step();
      rst_b = 1'b1;
      step();
      chk("post_rst_rdy", {31'd0, rdy}, 32'd1);
      chk("post_rst_no_resp", {31'd0, resp_vld}, 32'd0);
      txn(32'hE000_0304, 1'b0, 32'h0, 1, 32'h3141_5926, 1'b1);

      step();
      chk("sb_drained", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
